// File: rtl/hub75_scan_scheduler.sv
// HUB75 scan scheduler: walks rows and BCM bit-planes, drives latch/OE/row address, owns the display buffer select.
// Define HUB75_SCHED_BLANK_EN to insert BLANK_TICKS dead-time clocks between the line shift and the latch.
module hub75_scan_scheduler #(
  parameter int ROW_BITS    = 4,
  parameter int PLANES      = 4,
  parameter int BASE_TICKS  = 8,
  parameter int BLANK_TICKS = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [7:0]          brightness_i,
  input  logic                swap_req_i,
  output logic                swap_ack_o,
  output logic                buffer_sel_o,
  output logic                shift_start_o,
  output logic [ROW_BITS-1:0] shift_row_o,
  output logic [2:0]          shift_plane_o,
  input  logic                shift_done_i,
  output logic [ROW_BITS-1:0] row_addr_o,
  output logic                latch_o,
  output logic                oe_n_o,
  output logic                frame_start_o
);

  // One counter serves both the blanking interval and the display on-time.
  localparam int PROD_W  = $clog2(BASE_TICKS + 1) + PLANES + 8;
  localparam int BLANK_W = $clog2(BLANK_TICKS + 1);
  localparam int TICK_W  = (PROD_W > BLANK_W) ? PROD_W : BLANK_W;

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY, FRAME_END} state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [2:0]          plane_q, plane_d;
  logic [7:0]          bright_q, bright_d;
  logic                first_q, first_d;
  logic [TICK_W-1:0]   cnt_q, cnt_d;
  logic [TICK_W-1:0]   on_q, on_d;
  logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
  logic                buf_q, buf_d;
  logic                frame_start_q, frame_start_d;

  logic [TICK_W-1:0]   plane_base;
  logic [TICK_W-1:0]   on_prod;
  logic [TICK_W-1:0]   on_ticks;
  logic [TICK_W-1:0]   last_tick;

  // Full-width product before the /256 so low brightness keeps its precision.
  assign plane_base = TICK_W'(BASE_TICKS) << plane_q;
  assign on_prod    = plane_base * TICK_W'({1'b0, bright_q} + 9'd1);
  assign on_ticks   = on_prod >> 8;
  assign last_tick  = (on_q == '0) ? TICK_W'(1) : on_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      row_q         <= '0;
      plane_q       <= '0;
      bright_q      <= '0;
      first_q       <= 1'b0;
      cnt_q         <= '0;
      on_q          <= '0;
      row_addr_q    <= '0;
      buf_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      bright_q      <= bright_d;
      first_q       <= first_d;
      cnt_q         <= cnt_d;
      on_q          <= on_d;
      row_addr_q    <= row_addr_d;
      buf_q         <= buf_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    plane_d       = plane_q;
    bright_d      = bright_q;
    first_d       = 1'b0;
    cnt_d         = cnt_q;
    on_d          = on_q;
    row_addr_d    = row_addr_q;
    buf_d         = buf_q;
    frame_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          bright_d      = brightness_i;
          frame_start_d = 1'b1;
          row_d         = '0;
          plane_d       = '0;
          first_d       = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        // A done pulse coincident with our own start belongs to no line of ours.
        if (!first_q && shift_done_i) begin
          row_addr_d = row_q;
`ifdef HUB75_SCHED_BLANK_EN
          cnt_d      = '0;
          state_d    = BLANK;
`else
          state_d    = LATCH;
`endif
        end
      end
`ifdef HUB75_SCHED_BLANK_EN
      BLANK: begin
        if (cnt_q == TICK_W'(BLANK_TICKS - 1)) begin
          state_d = LATCH;
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end
`endif
      LATCH: begin
        on_d    = on_ticks;
        cnt_d   = '0;
        state_d = DISPLAY;
      end
      DISPLAY: begin
        // cnt_q == last_tick is the advance cycle, OE already released.
        if (cnt_q == last_tick) begin
          first_d = 1'b1;
          state_d = SHIFT;
          if (plane_q == 3'(PLANES - 1)) begin
            plane_d = '0;
            if (row_q == '1) begin
              row_d   = '0;
              first_d = 1'b0;
              state_d = FRAME_END;
            end else begin
              row_d = row_q + ROW_BITS'(1);
            end
          end else begin
            plane_d = plane_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + TICK_W'(1);
        end
      end
      FRAME_END: begin
        if (swap_req_i) begin
          buf_d = ~buf_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign swap_ack_o    = (state_q == FRAME_END) && swap_req_i;
  assign buffer_sel_o  = buf_q ^ swap_ack_o;
  assign shift_start_o = (state_q == SHIFT) && first_q;
  assign shift_row_o   = row_q;
  assign shift_plane_o = plane_q;
  assign row_addr_o    = row_addr_q;
  assign latch_o       = (state_q == LATCH);
  assign oe_n_o        = !((state_q == DISPLAY) && (cnt_q < on_q));
  assign frame_start_o = frame_start_q;

endmodule

// File: doc/hub75_scan_scheduler.md
# hub75_scan_scheduler

Sequences HUB75 panel refresh with binary-coded modulation (BCM): steps through every row and bit-plane, commands the line shifter, and drives latch, OE and row address. Exposes a global brightness control and owns the double-buffer select, flipping it only at frame boundaries on request from the SPI write side. Sits between the pixel-clock domain line shifter and the panel pins; all ports share the pixel clock.

## Interface
- ROW_BITS, 4, row address width; the scheduler scans 2^ROW_BITS rows.
- PLANES, 4, number of BCM bit-planes, 1..8.
- BASE_TICKS, 8, OE on-time in clocks for plane 0 at full brightness.
- BLANK_TICKS, 2, dead-time clocks before latch, used only with the blanking feature.

- clk  in  1  pixel clock; all logic on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  run scanning; sampled only in IDLE.
- brightness  in  8  global brightness, sampled at frame start.
- swap_req  in  1  level request to flip buffers; held by the requester until swap_ack.
- swap_ack  out  1  one-cycle pulse when the flip occurs.
- buffer_sel  out  1  buffer currently displayed.
- shift_start  out  1  one-cycle pulse commanding a line shift.
- shift_row  out  ROW_BITS  row being shifted; held from shift_start until shift_done.
- shift_plane  out  3  plane being shifted; held likewise.
- shift_done  in  1  one-cycle pulse from the shifter, line complete.
- row_addr  out  ROW_BITS  panel row address.
- latch  out  1  panel latch strobe.
- oe_n  out  1  panel output enable, active-low.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- Reset values: oe_n=1, latch=0, row_addr=0, shift_start=0, shift_row=0, shift_plane=0, buffer_sel=0, swap_ack=0, frame_start=0, state IDLE.
- States: IDLE, SHIFT, BLANK, LATCH, DISPLAY, FRAME_END.
- IDLE: oe_n=1. If enable=1, capture brightness, pulse frame_start, set row=0 and plane=0, then go to SHIFT.
- SHIFT: shift_start is high on the first cycle only. shift_done is ignored on that first cycle. The state is held until shift_done arrives, then goes to BLANK. oe_n stays at its previous value, so the prior plane's display is already complete.
- BLANK: oe_n=1, and row_addr is loaded with shift_row on entry. Lasts BLANK_TICKS cycles, then goes to LATCH.
- LATCH: latch=1 for exactly one cycle, oe_n=1, then goes to DISPLAY.
- DISPLAY on-time: on_ticks = ((BASE_TICKS << plane) × (brightness_cap + 1)) >> 8. The product is computed at full width, at least log2(BASE_TICKS) + PLANES + 8 bits, with no truncation before the shift.
- DISPLAY output: oe_n=0 for exactly on_ticks cycles. If on_ticks = 0, oe_n stays 1 and DISPLAY lasts 1 cycle.
- DISPLAY exit: oe_n returns to 1 on the cycle after the last on-tick.
- Advance after DISPLAY: plane+1. When plane wraps from PLANES-1 to 0, row+1. Go to SHIFT, except after row 2^ROW_BITS-1, plane PLANES-1, go to FRAME_END.
- FRAME_END, one cycle: if swap_req=1, toggle buffer_sel and pulse swap_ack in the same cycle. Then go to IDLE.
- A swap_req arriving mid-frame waits for FRAME_END. swap_req low at FRAME_END means no flip.
- enable falling mid-frame has no effect until IDLE, so a frame always completes.
- Reset mid-frame returns all outputs to reset values immediately (asynchronous). buffer_sel returns to 0.

## Timing
- IDLE to the first shift_start: 1 cycle.
- Per plane: 1 (start) + N (shift wait) + BLANK_TICKS + 1 (latch) + max(on_ticks, 1) + 1 (advance) cycles.
- Frame-to-frame overhead: FRAME_END plus IDLE, 2 cycles.
- swap_ack and the buffer_sel change are coincident.

## Configuration
- HUB75_SCHED_BLANK_EN defined: the BLANK state is present, as described above.
- HUB75_SCHED_BLANK_EN undefined: SHIFT goes directly to LATCH. row_addr is loaded from shift_row in the LATCH cycle. BLANK_TICKS is unused.

## Test plan
- Reset mid-DISPLAY with oe_n=0 -> oe_n=1, latch=0, row_addr=0 and buffer_sel=0 in the same cycle; stays IDLE while enable=0.
- ROW_BITS=4, PLANES=4, BASE_TICKS=8, brightness=255, shifter replies 3 cycles after start -> plane 0..3 on_ticks 8/16/32/64; 64 shift_start pulses per frame; latch is exactly 1 cycle each.
- brightness=127 -> plane 3 oe_n low for 32 cycles; brightness=0 -> planes 0..3 on_ticks 0/0/0/0 and oe_n never goes low.
- swap_req raised at row 5 and held -> buffer_sel toggles and swap_ack pulses once, both at FRAME_END; next frame_start follows 1 cycle after IDLE entry.
- shift_done asserted coincident with shift_start -> ignored; the scheduler waits for the next shift_done.
- With and without HUB75_SCHED_BLANK_EN, BLANK_TICKS=2 -> cycles from shift_done to latch are 3 with the macro and 1 without; row_addr changes only at BLANK entry or at LATCH respectively.
